// File: rtl/shru_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shru_pkg
// Brief    : Shared types and helpers for the shadow-register store queue.
// Revision : 1.0 - initial release
// ============================================================================
package shru_pkg;

    localparam int SHRU_XLEN_MAX      = 64;
    localparam int SHRU_PAGE_OFFSET_W = 12;

    // Fields are sized for the widest XLEN; narrower builds use the low bits.
    typedef struct packed {
        logic [SHRU_XLEN_MAX-1:0] addr;
        logic [SHRU_XLEN_MAX-1:0] data;
        logic                     last;
    } shru_store_entry_t;

    // Lowest address bit that distinguishes one XLEN-aligned word from the next.
    function automatic int word_lsb(input int data_width);
        return (data_width == 32) ? 2 : 3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shru_store_queue.sv
`default_nettype none
// ============================================================================
// Module   : shru_store_queue
// Brief    : In-order store queue from the shadow-register save FSM to the
//            dcache store port, with frame-done and page-offset hazard reporting.
// Revision : 1.0 - initial release
// ============================================================================
module shru_store_queue
    import shru_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          push_valid_i,
    output logic                          push_ready_o,
    input  logic [DATA_WIDTH-1:0]         push_addr_i,
    input  logic [DATA_WIDTH-1:0]         push_data_i,
    input  logic                          push_last_i,
    output logic                          mem_req_o,
    input  logic                          mem_gnt_i,
    output logic [DATA_WIDTH-1:0]         mem_addr_o,
    output logic [DATA_WIDTH-1:0]         mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0]       mem_be_o,
    output logic                          frame_done_o,
    output logic                          empty_o,
    output logic [$clog2(DEPTH+1)-1:0]    level_o,
    input  logic [SHRU_PAGE_OFFSET_W-1:0] page_offset_i,
    output logic                          page_offset_match_o
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = $clog2(DEPTH+1);
    localparam int c_LSB   = word_lsb(DATA_WIDTH);

    shru_store_entry_t  r_mem [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic               r_frame_done;

    logic               w_push;
    logic               w_pop;
    logic [DEPTH-1:0]   w_hit;
    shru_store_entry_t  w_push_entry;
    shru_store_entry_t  w_head;

    // Full/empty come from the level counter only; no same-cycle pass-through.
    assign push_ready_o = (r_level != c_LVL_W'(DEPTH));
    assign empty_o      = (r_level == '0);
    assign level_o      = r_level;
    assign mem_req_o    = !empty_o;

    assign w_push = push_valid_i && push_ready_o;
    assign w_pop  = mem_req_o && mem_gnt_i;

    assign w_push_entry.addr = SHRU_XLEN_MAX'(push_addr_i);
    assign w_push_entry.data = SHRU_XLEN_MAX'(push_data_i);
    assign w_push_entry.last = push_last_i;

    assign w_head       = r_mem[r_rd_ptr];
    assign mem_addr_o   = w_head.addr[DATA_WIDTH-1:0];
    assign mem_wdata_o  = w_head.data[DATA_WIDTH-1:0];
    assign mem_be_o     = '1;
    assign frame_done_o = r_frame_done;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_entry;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_pop && w_head.last;
            // Push and pop never target the same slot: pop needs a non-empty
            // queue and push a non-full one.
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Hazard compare against stored words only; an incoming push is not seen yet.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        assign w_hit[gi] = r_valid[gi] &&
            (r_mem[gi].addr[SHRU_PAGE_OFFSET_W-1:c_LSB] ==
             page_offset_i[SHRU_PAGE_OFFSET_W-1:c_LSB]);
    end

    assign page_offset_match_o = |w_hit;

    a_level_bound : assert property (@(posedge clk_i) disable iff (rst_i)
        r_level <= c_LVL_W'(DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_shru_store_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_shru_store_queue
// Brief    : Directed self-checking bench for shru_store_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shru_store_queue;
    import shru_pkg::*;

    localparam int DATA_WIDTH = 64;
    localparam int DEPTH      = 4;

    logic                          clk;
    logic                          rst;
    logic                          push_valid;
    logic                          push_ready;
    logic [DATA_WIDTH-1:0]         push_addr;
    logic [DATA_WIDTH-1:0]         push_data;
    logic                          push_last;
    logic                          mem_req;
    logic                          mem_gnt;
    logic [DATA_WIDTH-1:0]         mem_addr;
    logic [DATA_WIDTH-1:0]         mem_wdata;
    logic [DATA_WIDTH/8-1:0]       mem_be;
    logic                          frame_done;
    logic                          empty;
    logic [$clog2(DEPTH+1)-1:0]    level;
    logic [SHRU_PAGE_OFFSET_W-1:0] page_offset;
    logic                          page_match;

    int n_vec = 0;
    int n_err = 0;

    shru_store_queue #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .push_valid_i        (push_valid),
        .push_ready_o        (push_ready),
        .push_addr_i         (push_addr),
        .push_data_i         (push_data),
        .push_last_i         (push_last),
        .mem_req_o           (mem_req),
        .mem_gnt_i           (mem_gnt),
        .mem_addr_o          (mem_addr),
        .mem_wdata_o         (mem_wdata),
        .mem_be_o            (mem_be),
        .frame_done_o        (frame_done),
        .empty_o             (empty),
        .level_o             (level),
        .page_offset_i       (page_offset),
        .page_offset_match_o (page_match)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_push(input logic v, input logic [63:0] a, input logic [63:0] d, input logic l);
        push_valid = v;
        push_addr  = a;
        push_data  = d;
        push_last  = l;
    endtask

    initial begin
        rst = 1'b1;
        mem_gnt = 1'b0;
        page_offset = '0;
        set_push(1'b0, '0, '0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        check("rst_req",   64'(mem_req),    64'd0);
        check("rst_ready", 64'(push_ready), 64'd1);
        check("rst_level", 64'(level),      64'd0);
        check("rst_empty", 64'(empty),      64'd1);
        check("rst_fdone", 64'(frame_done), 64'd0);
        check("rst_match", 64'(page_match), 64'd0);
        check("be_ones",   64'(mem_be),     64'hFF);

        // Two-word frame, held without grant, then granted in order
        set_push(1'b1, 64'h8000_1000, 64'hAA, 1'b0);
        tick();
        check("f_req1",   64'(mem_req), 64'd1);
        check("f_addr1",  mem_addr,     64'h8000_1000);
        set_push(1'b1, 64'h8000_1008, 64'hBB, 1'b1);
        tick();
        set_push(1'b0, '0, '0, 1'b0);
        check("f_level2", 64'(level), 64'd2);
        tick();
        check("f_hold_addr", mem_addr,    64'h8000_1000);
        check("f_hold_req",  64'(mem_req), 64'd1);
        mem_gnt = 1'b1;
        check("f_data_aa", mem_wdata, 64'hAA);
        tick();
        check("f_data_bb", mem_wdata, 64'hBB);
        check("f_addr_bb", mem_addr,  64'h8000_1008);
        check("f_fdone0",  64'(frame_done), 64'd0);
        tick();
        mem_gnt = 1'b0;
        check("f_fdone1",  64'(frame_done), 64'd1);
        check("f_empty",   64'(empty),      64'd1);
        tick();
        check("f_fdone_once", 64'(frame_done), 64'd0);

        // Fill to DEPTH, 5th push refused, then push stalls one cycle under grant
        for (int i = 0; i < DEPTH; i++) begin
            set_push(1'b1, 64'h100 + 64'(8*i), 64'(i), 1'b0);
            tick();
        end
        check("full_level", 64'(level),      64'd4);
        check("full_ready", 64'(push_ready), 64'd0);
        set_push(1'b1, 64'h200, 64'h55, 1'b0);
        tick();
        check("full_no_take", 64'(level), 64'd4);
        mem_gnt = 1'b1;
        tick();
        check("stall_level", 64'(level),      64'd3);
        check("stall_ready", 64'(push_ready), 64'd1);
        check("stall_head",  mem_wdata,       64'd1);
        tick();
        set_push(1'b0, '0, '0, 1'b0);
        check("accept_level", 64'(level), 64'd3);
        check("drain_0", mem_wdata, 64'd2);
        tick();
        check("drain_1", mem_wdata, 64'd3);
        tick();
        check("drain_2", mem_wdata, 64'h55);
        tick();
        mem_gnt = 1'b0;
        check("drain_empty", 64'(empty), 64'd1);

        // Streaming wrap-around: level stays 1, order preserved
        set_push(1'b1, 64'h9000_0000, 64'h1000, 1'b0);
        tick();
        mem_gnt = 1'b1;
        for (int i = 1; i < 10; i++) begin
            set_push(1'b1, 64'h9000_0000 + 64'(8*i), 64'h1000 + 64'(i), 1'b0);
            check($sformatf("wrap_data%0d", i-1), mem_wdata, 64'h1000 + 64'(i-1));
            tick();
            check($sformatf("wrap_level%0d", i), 64'(level), 64'd1);
        end
        set_push(1'b0, '0, '0, 1'b0);
        check("wrap_data9", mem_wdata, 64'h1009);
        check("wrap_addr9", mem_addr,  64'h9000_0048);
        tick();
        mem_gnt = 1'b0;
        check("wrap_empty", 64'(empty), 64'd1);

        // Page-offset hazard
        page_offset = 12'hFF8;
        set_push(1'b1, 64'h8000_2FF8, 64'h77, 1'b0);
        #1;
        check("po_push_excl", 64'(page_match), 64'd0);
        tick();
        set_push(1'b0, '0, '0, 1'b0);
        #1;
        check("po_hit",  64'(page_match), 64'd1);
        page_offset = 12'hFF0;
        #1;
        check("po_miss", 64'(page_match), 64'd0);
        page_offset = 12'hFF8;
        mem_gnt = 1'b1;
        #1;
        check("po_hit_req", 64'(page_match), 64'd1);
        tick();
        mem_gnt = 1'b0;
        check("po_after_gnt", 64'(page_match), 64'd0);

        // Reset with words queued discards them; later grant does nothing
        for (int i = 0; i < 3; i++) begin
            set_push(1'b1, 64'h300 + 64'(8*i), 64'hC0 + 64'(i), 1'b1);
            tick();
        end
        set_push(1'b0, '0, '0, 1'b0);
        check("mr_level3", 64'(level),   64'd3);
        check("mr_req",    64'(mem_req), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_req0",   64'(mem_req), 64'd0);
        check("mr_level0", 64'(level),   64'd0);
        mem_gnt = 1'b1;
        tick();
        check("mr_gnt_level", 64'(level),      64'd0);
        check("mr_gnt_fdone", 64'(frame_done), 64'd0);
        tick();
        mem_gnt = 1'b0;
        check("mr_gnt_fdone2", 64'(frame_done), 64'd0);
        check("mr_empty",      64'(empty),      64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
